if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Fetch stage directly downstream of the PC. Takes the PC's fetch address (PC_Addr) and return address (PC_save), issues in-order requests to instruction memory, and buffers returned instructions in a DEPTH-slot in-order queue. Presents {instr, pc, pc_save} to decode over a valid/ready handshake. Back-pressures the PC with pc_stall and discards wrong-path fetches on a redirect flush (MPC/JALR).

Parameters:
size, 32, address/PC width
DEPTH, 4, slot count; power of 2, >= 2; also the cap on outstanding requests plus queued entries

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
pc_addr  in  size  current fetch address from PC
pc_save  in  size  PC+4 from PC, carried with the instruction
pc_stall  out  1  1 = address not taken this cycle; PC must hold
flush  in  1  redirect (MPC or JALR); discard all wrong-path state
imem_req  out  1  fetch request
imem_addr  out  size  request address (= pc_addr)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid; responses return strictly in request order
imem_rdata  in  32  instruction word
id_valid  out  1  decode slot valid
id_ready  in  1  decode accepts
id_instr  out  32  instruction
id_pc  out  size  its address
id_pc_save  out  size  its PC+4

Behaviour:
- State:
  - slot array of DEPTH x {pc, pc_save, instr, filled}
  - alloc_ptr, fill_ptr, pop_ptr, each log2(DEPTH)+1 bits, wrapping naturally
  - drop_cnt, log2(DEPTH)+1 bits
- Derived counts:
  - used = alloc_ptr - pop_ptr
  - inflight = alloc_ptr - fill_ptr
- Reset (reset==0 at edge):
  - All pointers and drop_cnt go to 0; all filled bits go to 0.
  - While reset is low: imem_req=0, id_valid=0, pc_stall=1.
  - Reset mid-operation discards everything; later imem_rvalid pulses are ignored while drop_cnt==0 and inflight==0.
- Issue (combinational):
  - imem_req = reset & ~flush & (used + drop_cnt < DEPTH).
  - imem_addr = pc_addr.
  - On imem_req & imem_gnt: slot[alloc_ptr] gets {pc_addr, pc_save, filled=0}; alloc_ptr++.
  - pc_stall = ~(imem_req & imem_gnt), except during flush, where pc_stall=0 so the PC loads its redirect target.
- Response:
  - On imem_rvalid with drop_cnt != 0: discard the word, decrement drop_cnt.
  - On imem_rvalid with drop_cnt == 0 and inflight != 0: write slot[fill_ptr].instr, set filled, fill_ptr++.
  - imem_rvalid with nothing outstanding is ignored; the bench asserts on it.
- Output:
  - id_valid = (fill_ptr != pop_ptr) & ~flush & reset.
  - id_* outputs driven from slot[pop_ptr].
  - Pop (pop_ptr++) on id_valid & id_ready.
  - id_* stay stable while id_valid & ~id_ready.
- Latency: grant at cycle N with rvalid at N+1 gives id_valid at N+2. Steady-state throughput is 1 instr/cycle when DEPTH >= memory latency + 1.
- Flush (highest priority):
  - alloc_ptr and fill_ptr go to pop_ptr; filled bits are cleared; no pop, no issue.
  - drop_cnt_next = drop_cnt + inflight - (imem_rvalid ? 1 : 0). The response arriving in the flush cycle belongs to the old stream.
- Draining (drop_cnt != 0):
  - New requests may issue, within the credit limit.
  - Discarded responses are identified purely by count, relying on in-order return.
- Full: used + drop_cnt == DEPTH gives imem_req=0 and pc_stall=1. A simultaneous pop frees a credit only in the next cycle (no same-cycle pass-through).
- Empty: id_valid=0. There is no combinational bypass from imem_rdata to id_instr.

Decomposition:
- Package fetch_pkg:
  - INSTR_W=32
  - NOP_INSTR=32'h00000013 (value driven on id_instr when !id_valid)
  - slot struct {pc, pc_save, instr, filled}
  - pointer-width function clog2(DEPTH)+1
- One natural sub-module: fetch_slot_array. It holds the DEPTH-entry storage with separate allocate-write, fill-write and read ports. Pointer and credit logic stay in the top.

Test Plan:
- Reset low for 4 cycles, then high; memory grants always, 1-cycle latency, rdata=addr^32'hA5A5_0000; PC from 0 → id_valid first at cycle 2 after the first grant; id stream shows pc 0,4,8 with instr 32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008 and pc_save = pc+4.
- id_ready=0 from start, DEPTH=4 → exactly 4 grants, then pc_stall=1 and imem_req=0. Raise id_ready → one pop per cycle; first new grant comes one cycle after the first pop.
- 3-cycle memory latency with 3 outstanding requests (addr 0x10,0x14,0x18), flush asserted together with the rvalid for 0x10 → drop_cnt=2. Next two rvalids discarded. First instruction after redirect (pc_addr=0x100) appears with id_pc=0x100.
- imem_gnt held 0 for 5 cycles → pc_stall=1 every cycle, no slot allocated, id_valid stays 0.
- Reset asserted while 2 requests outstanding and 1 entry queued → id_valid=0 next cycle. Late rvalids ignored. Fetch resumes cleanly from the PC's reset address.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, slot layout and pointer sizing for the fetch queue.
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [PC_W-1:0]    pc_save;
      logic [INSTR_W-1:0] instr;
      logic               filled;
   } slot_t;

   // One extra bit over the index so full and empty are distinguishable.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_slot_array.sv
// DEPTH-entry fetch slot storage: one allocate write port, one fill write
// port and one asynchronous read port. Only the filled bits are reset.
module fetch_slot_array
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int IW   = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               alloc_en,
   input  logic [IW-1:0]      alloc_idx,
   input  logic [PC_W-1:0]    alloc_pc,
   input  logic [PC_W-1:0]    alloc_pc_save,
   input  logic               fill_en,
   input  logic [IW-1:0]      fill_idx,
   input  logic [INSTR_W-1:0] fill_instr,
   input  logic [IW-1:0]      rd_idx,
   output slot_t              rd_slot
);

   logic [PC_W-1:0]    pc_mem    [DEPTH];
   logic [PC_W-1:0]    save_mem  [DEPTH];
   logic [INSTR_W-1:0] instr_mem [DEPTH];
   logic               filled    [DEPTH];

   // Allocate and fill never target the same slot: fill only hits allocated ones.
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         for (int i = 0; i < DEPTH; i++) filled[i] <= 1'b0;
      end else begin
         if (alloc_en) filled[alloc_idx] <= 1'b0;
         if (fill_en)  filled[fill_idx]  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_en) begin
         pc_mem[alloc_idx]   <= alloc_pc;
         save_mem[alloc_idx] <= alloc_pc_save;
      end
      if (fill_en) instr_mem[fill_idx] <= fill_instr;
   end

   always_comb begin
      rd_slot         = '0;
      rd_slot.pc      = pc_mem[rd_idx];
      rd_slot.pc_save = save_mem[rd_idx];
      rd_slot.instr   = instr_mem[rd_idx];
      rd_slot.filled  = filled[rd_idx];
   end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: issues in-order imem requests within a DEPTH credit limit,
// buffers responses in order and discards wrong-path responses after a flush.
module if_fetch_queue
   import fetch_pkg::*;
#(
   parameter int size  = 32,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [size-1:0]    pc_addr,
   input  logic [size-1:0]    pc_save,
   output logic               pc_stall,
   input  logic               flush,
   output logic               imem_req,
   output logic [size-1:0]    imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [size-1:0]    id_pc,
   output logic [size-1:0]    id_pc_save
);

   localparam int PW = ptr_width(DEPTH);
   localparam int IW = PW - 1;
   localparam logic [PW-1:0] ONE     = PW'(1);
   localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);

   logic [PW-1:0]   alloc_ptr, fill_ptr, pop_ptr, drop_cnt;
   logic [PW-1:0]   used, inflight;
   logic [PW:0]     credit_use;
   logic            grant, fill_take, pop, draining, flush_hit;
   logic [PC_W-1:0] alloc_pc, alloc_pc_save;
   slot_t           rd_slot;

   assign used       = alloc_ptr - pop_ptr;
   assign inflight   = alloc_ptr - fill_ptr;
   assign credit_use = {1'b0, used} + {1'b0, drop_cnt};
   assign draining   = (drop_cnt != '0);

   assign imem_req  = reset & ~flush & (credit_use < DEPTH_C);
   assign imem_addr = pc_addr;
   assign grant     = imem_req & imem_gnt;
   // During a flush the PC must move to its redirect target, so never stall it.
   assign pc_stall  = ~reset | (~flush & ~grant);

   assign fill_take = reset & ~flush & imem_rvalid & ~draining & (inflight != '0);
   // A response in the flush cycle belongs to the old stream and is counted out.
   assign flush_hit = imem_rvalid & ((drop_cnt + inflight) != '0);

   // Decode handshake: an entry transfers on a rising edge with id_valid and
   // id_ready both high; while id_valid & ~id_ready the id_* outputs hold.
   assign id_valid   = reset & ~flush & (fill_ptr != pop_ptr) & rd_slot.filled;
   assign pop        = id_valid & id_ready;
   assign id_instr   = id_valid ? rd_slot.instr : NOP_INSTR;
   assign id_pc      = rd_slot.pc[size-1:0];
   assign id_pc_save = rd_slot.pc_save[size-1:0];

   always_comb begin
      alloc_pc                   = '0;
      alloc_pc_save              = '0;
      alloc_pc[size-1:0]         = pc_addr;
      alloc_pc_save[size-1:0]    = pc_save;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         pop_ptr   <= '0;
         drop_cnt  <= '0;
      end else if (flush) begin
         alloc_ptr <= pop_ptr;
         fill_ptr  <= pop_ptr;
         drop_cnt  <= drop_cnt + inflight - (flush_hit ? ONE : '0);
      end else begin
         if (grant)     alloc_ptr <= alloc_ptr + ONE;
         if (fill_take) fill_ptr  <= fill_ptr + ONE;
         if (pop)       pop_ptr   <= pop_ptr + ONE;
         if (imem_rvalid && draining) drop_cnt <= drop_cnt - ONE;
      end
   end

   fetch_slot_array #(.DEPTH(DEPTH)) u_slots (
      .clk           (clk),
      .reset         (reset),
      .clear         (flush),
      .alloc_en      (grant),
      .alloc_idx     (alloc_ptr[IW-1:0]),
      .alloc_pc      (alloc_pc),
      .alloc_pc_save (alloc_pc_save),
      .fill_en       (fill_take),
      .fill_idx      (fill_ptr[IW-1:0]),
      .fill_instr    (imem_rdata),
      .rd_idx        (pop_ptr[IW-1:0]),
      .rd_slot       (rd_slot)
   );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: PC model, in-order memory model with
// configurable latency, and a scoreboard of expected {pc, pc_save, instr}.
module tb_if_fetch_queue;

   localparam int W = 96;
   localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        id_ready = 1'b0;
   logic [31:0] pc_addr = 32'h0;
   logic [31:0] pc_save = 32'h4;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        pc_stall, imem_req, id_valid;
   logic [31:0] imem_addr, id_instr, id_pc, id_pc_save;

   if_fetch_queue dut (
      .clk         (clk),
      .reset       (reset),
      .pc_addr     (pc_addr),
      .pc_save     (pc_save),
      .pc_stall    (pc_stall),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_pc_save  (id_pc_save)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- shared bench state ----------------
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          mem_lat = 1;
   logic        mem_gnt_en = 1'b1;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] pc_cur = 32'h0;
   logic [31:0] pc_n = 32'h0;
   logic [31:0] resp_addr = 32'h0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [W-1:0] exp_q[$];
   int          grant_cnt = 0;
   int          pop_cnt = 0;
   int          first_grant = -1;
   int          first_valid = -1;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver: PC and memory, at negedge+1 ----------------
   always @(negedge clk) begin
      #1;
      pc_cur   = pc_n;
      pc_addr  = pc_cur;
      pc_save  = pc_cur + 32'd4;
      imem_gnt = mem_gnt_en;
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         resp_addr   = pend_addr[0];
         imem_rdata  = pend_addr[0] ^ XOR_PAT;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0;
      end
   end

   // ---------------- monitor + scoreboard, at negedge+4 (1 before posedge) ----------------
   always @(negedge clk) begin
      logic [W-1:0] exp_v;
      #4;
      if (imem_rvalid === 1'b1 && pend_addr.size() != 0) begin
         pend_addr.delete(0);
         pend_due.delete(0);
      end
      if (reset !== 1'b1) begin
         exp_q.delete();
         pc_n        = 32'h0;
         first_grant = -1;
         first_valid = -1;
      end else if (flush === 1'b1) begin
         exp_q.delete();
         pc_n = redirect_pc;
      end else begin
         if (id_valid === 1'b1 && first_valid < 0) first_valid = cyc;
         if (id_valid === 1'b1 && id_ready === 1'b1) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
               check("pop_empty_q", W'(exp_q.size()), W'(1));
            end else begin
               exp_v = exp_q.pop_front();
               check("pop_data", {id_pc, id_pc_save, id_instr}, exp_v);
            end
         end
         if (pc_stall === 1'b0) pc_n = pc_cur + 32'd4;
      end
      if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
         check("req_addr", W'(imem_addr), W'(pc_cur));
         pend_addr.push_back(pc_cur);
         pend_due.push_back(cyc + mem_lat);
         exp_q.push_back({pc_cur, pc_cur + 32'd4, pc_cur ^ XOR_PAT});
         grant_cnt++;
         if (first_grant < 0) first_grant = cyc;
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      reset = 1'b0;
      @(negedge clk);
      #2;
      check("rst_req", W'(imem_req), W'(0));
      check("rst_valid", W'(id_valid), W'(0));
      check("rst_stall", W'(pc_stall), W'(1));
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int g_base;
      int p_base;
      int i;

      // Basic stream: always grant, 1-cycle latency, decode always ready.
      id_ready = 1'b1; mem_lat = 1; mem_gnt_en = 1'b1;
      p_base = pop_cnt;
      do_reset();
      i = 0;
      while ((pop_cnt - p_base) < 6 && i < 40) begin
         @(negedge clk);
         i++;
      end
      check("t1_pops", W'((pop_cnt - p_base) >= 6), W'(1));
      check("t1_latency", W'(first_valid - first_grant), W'(2));

      // Back-pressure: decode stalled, queue fills to DEPTH.
      id_ready = 1'b0;
      g_base = grant_cnt;
      do_reset();
      repeat (8) @(negedge clk);
      #2;
      check("t2_grants", W'(grant_cnt - g_base), W'(4));
      check("t2_full_req", W'(imem_req), W'(0));
      check("t2_full_stall", W'(pc_stall), W'(1));
      check("t2_hold_valid", W'(id_valid), W'(1));
      check("t2_hold_pc", W'(id_pc), W'(32'h0));
      check("t2_hold_instr", W'(id_instr), W'(XOR_PAT));
      @(negedge clk);
      id_ready = 1'b1;
      #2;
      check("t2_no_passthru", W'(imem_req), W'(0));
      @(negedge clk);
      #2;
      check("t2_regrant", W'(imem_req & imem_gnt), W'(1));
      check("t2_second_pc", W'(id_pc), W'(32'h4));
      @(negedge clk);

      // Grant withheld: nothing allocates, PC holds.
      mem_gnt_en = 1'b0;
      g_base = grant_cnt;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         #2;
         check("t4_stall", W'(pc_stall), W'(1));
         check("t4_valid", W'(id_valid), W'(0));
         check("t4_req", W'(imem_req), W'(1));
         @(negedge clk);
      end
      check("t4_no_alloc", W'(grant_cnt - g_base), W'(0));
      mem_gnt_en = 1'b1;
      i = 0;
      #2;
      while (id_valid !== 1'b1 && i < 20) begin
         @(negedge clk);
         #2;
         i++;
      end
      check("t4_resume_valid", W'(id_valid), W'(1));
      check("t4_resume_pc", W'(id_pc), W'(32'h0));
      @(negedge clk);

      // Flush with three outstanding requests and a response in the flush cycle.
      id_ready = 1'b1; mem_lat = 1;
      do_reset();
      i = 0;
      #2;
      while (pc_cur != 32'h10 && i < 40) begin
         @(negedge clk);
         #2;
         i++;
      end
      check("t3_reach_10", W'(pc_cur), W'(32'h10));
      mem_lat = 3;
      @(negedge clk);
      i = 0;
      #2;
      while (!(imem_rvalid === 1'b1 && resp_addr == 32'h10) && i < 20) begin
         @(negedge clk);
         #2;
         i++;
      end
      check("t3_rvalid_10", W'(resp_addr), W'(32'h10));
      flush = 1'b1;
      redirect_pc = 32'h100;
      #1;
      check("t3_flush_req", W'(imem_req), W'(0));
      check("t3_flush_stall", W'(pc_stall), W'(0));
      check("t3_flush_valid", W'(id_valid), W'(0));
      @(negedge clk);
      flush = 1'b0;
      i = 0;
      #2;
      while (id_valid !== 1'b1 && i < 30) begin
         @(negedge clk);
         #2;
         i++;
      end
      check("t3_redirect_pc", W'(id_pc), W'(32'h100));
      check("t3_redirect_instr", W'(id_instr), W'(32'h100 ^ XOR_PAT));
      check("t3_redirect_save", W'(id_pc_save), W'(32'h104));
      @(negedge clk);

      // Reset with two requests outstanding and one entry queued.
      id_ready = 1'b0; mem_lat = 2; mem_gnt_en = 1'b1;
      g_base = grant_cnt;
      do_reset();
      i = 0;
      #2;
      while ((grant_cnt - g_base) != 3 && i < 20) begin
         @(negedge clk);
         #2;
         i++;
      end
      check("t5_three_grants", W'(grant_cnt - g_base), W'(3));
      check("t5_queued_valid", W'(id_valid), W'(1));
      check("t5_queued_pc", W'(id_pc), W'(32'h0));
      reset = 1'b0;
      mem_gnt_en = 1'b0;
      #1;
      check("t5_rst_valid", W'(id_valid), W'(0));
      check("t5_rst_req", W'(imem_req), W'(0));
      @(negedge clk);
      reset = 1'b1;
      #2;
      check("t5_late_valid", W'(id_valid), W'(0));
      check("t5_late_stall", W'(pc_stall), W'(1));
      @(negedge clk);
      #2;
      check("t5_ignored", W'(id_valid), W'(0));
      mem_gnt_en = 1'b1;
      id_ready = 1'b1;
      @(negedge clk);
      i = 0;
      #2;
      while (id_valid !== 1'b1 && i < 20) begin
         @(negedge clk);
         #2;
         i++;
      end
      check("t5_resume_pc", W'(id_pc), W'(32'h0));
      check("t5_resume_instr", W'(id_instr), W'(XOR_PAT));
      repeat (10) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
